// File: rtl/uart_pkg.sv
// Shared FSM type, oversampling constants and vote helper for the UART receiver.
package uart_pkg;

  localparam int OSR  = 16;
  localparam int OS_W = $clog2(OSR);

  // Mid-bit sample points used by the majority vote
  localparam logic [OS_W-1:0] VOTE_T0 = OS_W'(7);
  localparam logic [OS_W-1:0] VOTE_T1 = OS_W'(8);
  localparam logic [OS_W-1:0] VOTE_T2 = OS_W'(9);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every CLK_FREQ/(UART_BPS*16) clocks, re-phased by restart.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int RAW_DIV = CLK_FREQ / (UART_BPS * OSR);
  localparam int DIV     = (RAW_DIV < 1) ? 1 : RAW_DIV;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Restart aligns the tick phase to the detected start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (restart || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with 16x oversampling, 2-of-3 voting and a one-word holding register.
// Optional parity checking is compiled in with the macro UART_RX_PARITY_EN.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rxd,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_param: unsupported DATA_BITS/STOP_BITS/PARITY_ODD");
  end

  logic                 rxd_s1, rxd_s2, rxd_s3;
  logic                 start_edge, restart, tick, decide, bit_val, done, accept;
  logic [OS_W-1:0]      os_cnt;
  logic                 samp_a, samp_b;
  logic [2:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 stop_err, frame_flag;
  logic [DATA_BITS-1:0] shift_reg;
  rx_state_t            state, next_state;

  // Third flop only serves the falling-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_s3 <= 1'b1;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
    end
  end

  assign start_edge = rxd_s3 & ~rxd_s2;
  assign restart    = (state == IDLE) && start_edge;

  uart_baud_tick #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt <= '0;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (state == IDLE)
        os_cnt <= '0;
      else if (tick)
        os_cnt <= os_cnt + 1'b1;
      if (tick && os_cnt == VOTE_T0)
        samp_a <= rxd_s2;
      if (tick && os_cnt == VOTE_T1)
        samp_b <= rxd_s2;
    end
  end

  // Every bit is resolved at its third vote sample; states advance there
  assign decide  = tick && (state != IDLE) && (os_cnt == VOTE_T2);
  assign bit_val = maj3(samp_a, samp_b, rxd_s2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    done       = 1'b0;
    case (state)
      IDLE:   if (start_edge) next_state = START;
      START:  if (decide) next_state = bit_val ? IDLE : DATA;
      DATA:   if (decide && bit_cnt == LAST_BIT)
`ifdef UART_RX_PARITY_EN
                next_state = PARITY;
`else
                next_state = STOP;
`endif
      PARITY: if (decide) next_state = STOP;
      STOP: begin
        if (decide && stop_cnt == LAST_STOP) begin
          next_state = IDLE;
          done       = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      stop_err  <= 1'b0;
      shift_reg <= '0;
    end else if (decide) begin
      case (state)
        START: begin
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          stop_err <= 1'b0;
        end
        DATA: begin
          shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
          bit_cnt   <= bit_cnt + 1'b1;
        end
        STOP: begin
          stop_err <= stop_err | ~bit_val;
          stop_cnt <= stop_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The final stop bit is folded in combinationally on the completion cycle
  assign frame_flag = stop_err | ~bit_val;
  assign accept     = done && (!rx_valid || rx_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        rx_valid  <= 1'b1;
        rx_data   <= shift_reg;
        frame_err <= frame_flag;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (overrun_clr)
        overrun <= 1'b0;
      else if (done && rx_valid && !rx_ready)
        overrun <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);

  logic par_acc;

  // Running XOR over data bits and the received parity bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_acc <= 1'b0;
    else if (decide) begin
      if (state == START)
        par_acc <= 1'b0;
      else if (state == DATA || state == PARITY)
        par_acc <= par_acc ^ bit_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      parity_err <= 1'b0;
    else if (accept)
      parity_err <= (par_acc != PAR_SENSE);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200: line baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits checked, legal values 1 or 2.
REQ-005 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; used only when parity is compiled in.
REQ-006 SHALL have port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port uart_rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port rx_ready, input, 1 bit: consumer accepts the word when rx_valid=1.
REQ-010 SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed word.
REQ-011 SHALL have port rx_data, output, DATA_BITS bits: received word, LSB first on the line.
REQ-012 SHALL have port frame_err, output, 1 bit: a stop bit of the current word sampled low; qualified by rx_valid.
REQ-013 SHALL have port parity_err, output, 1 bit: parity mismatch on the current word; qualified by rx_valid.
REQ-014 SHALL have port overrun, output, 1 bit: sticky; a frame completed while rx_valid=1 and rx_ready=0.
REQ-015 SHALL have port overrun_clr, input, 1 bit: clears overrun on the next edge.

Function
REQ-016 SHALL synchronise uart_rxd through 2 flops; start detection SHALL use a third flop for the falling-edge detect.
REQ-017 SHALL generate a 16x oversample tick every OSR_DIV = CLK_FREQ/(UART_BPS*16) clocks; the divider SHALL restart on start detection.
REQ-018 SHALL run FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE SHALL move to START on a synchronised high-to-low edge.
REQ-020 Each bit SHALL be decided by a 2-of-3 majority vote of samples taken at oversample ticks 7, 8 and 9.
REQ-021 START SHALL return to IDLE (false start, no output) when the voted start bit is 1; otherwise START SHALL move to DATA.
REQ-022 DATA SHALL shift in exactly DATA_BITS bits LSB first, then move to PARITY when parity is compiled in, else to STOP.
REQ-023 PARITY SHALL compute the XOR of the data bits and the parity bit, and SHALL flag parity_err when the result ≠ PARITY_ODD.
REQ-024 STOP SHALL check STOP_BITS stop bits; any low voted stop bit SHALL set frame_err for that word.
REQ-025 Completion SHALL occur at the mid-point of the last stop bit.
REQ-026 rx_valid SHALL rise exactly 1 clock after completion; rx_data and the error flags SHALL be loaded in the same cycle.
REQ-027 After completion the FSM SHALL return to IDLE; a new start SHALL require the line to return high first.
REQ-028 rx_valid SHALL stay high with rx_data stable until a clock edge with rx_ready=1.
REQ-029 When completion and the rx_ready handshake coincide, the old word SHALL be consumed and the new word loaded, with rx_valid remaining 1.
REQ-030 When completion occurs with rx_valid=1 and rx_ready=0, the new word SHALL be dropped and overrun set; overrun_clr SHALL have priority over a simultaneous set.

Reset
REQ-031 Assertion of rst_n SHALL immediately force: FSM to IDLE, all counters to 0, synchroniser flops to 1, rx_valid=0, rx_data=0, frame_err=0, parity_err=0, overrun=0.
REQ-032 Reset mid-frame SHALL discard the partial frame; reception SHALL resume with the next falling edge after release.

Configuration
REQ-033 Macro UART_RX_PARITY_EN defined: the PARITY state, PARITY_ODD and the parity_err check SHALL be present.
REQ-034 Macro UART_RX_PARITY_EN undefined: the PARITY state SHALL be skipped and parity_err SHALL be tied to 0; the port SHALL remain.

Structure
REQ-035 Package uart_pkg SHALL hold the FSM state enum, the oversample constant 16, and the vote tick indices 7/8/9.
REQ-036 The tick divider SHALL be a sub-module uart_baud_tick (parameters CLK_FREQ, UART_BPS; ports clk, rst_n, restart, tick).

Verification
REQ-037 Send 8N1 0xA5 at 115200 with rx_ready=1 -> rx_valid pulses once, rx_data=0xA5, frame_err=0, parity_err=0.
REQ-038 Send a 0-going glitch shorter than 6 oversample ticks on an idle line -> no rx_valid, FSM back in IDLE.
REQ-039 With parity compiled in and even parity, send 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1.
REQ-040 Send 0x3C with the stop bit low -> rx_data=0x3C, frame_err=1; the next frame after the line returns high is received cleanly.
REQ-041 Hold rx_ready=0 and send 0x11 then 0x22 -> rx_data stays 0x11 and overrun=1; overrun_clr returns overrun to 0.
REQ-042 Assert rst_n low during data bit 4 of a frame, then release and send 0x5A -> all outputs are 0 during reset and rx_data=0x5A afterwards.
